// File: rtl/cordic_scheduler_pkg.sv
// Shared constants and types for the cordic scheduler slice.
package cordic_pkg;

  localparam logic MODE_ROT = 1'b0;
  localparam logic MODE_VEC = 1'b1;

  localparam int DEF_DW       = 16;
  localparam int DEF_CORE_LAT = 16;
  localparam int DEF_NUM_REQ  = 4;

  // Width of a {valid, id} tag for a given number of requesters.
  function automatic int tag_width(input int num_req);
    return $clog2(num_req) + 1;
  endfunction

  localparam int DEF_TAG_W = tag_width(DEF_NUM_REQ);

  typedef logic [DEF_TAG_W-1:0] tag_t;

endpackage

// File: rtl/cordic_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first eligible requester at or after rr_ptr.
module rr_arbiter
  import cordic_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible_i,
  input  logic [IDW-1:0]     rr_ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDW-1:0]     grant_idx_o,
  output logic               grant_vld_o
);

  // Scan rr_ptr, rr_ptr+1, ... modulo NUM_REQ and stop at the first eligible port.
  always_comb begin : scan
    int c;
    c           = 0;
    grant_o     = '0;
    grant_idx_o = '0;
    grant_vld_o = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = (int'(rr_ptr_i) + k) % NUM_REQ;
      if (!grant_vld_o && eligible_i[c]) begin
        grant_vld_o = 1'b1;
        grant_o[c]  = 1'b1;
        grant_idx_o = IDW'(c);
      end
    end
  end

endmodule

// File: rtl/cordic_scheduler.sv
// Shares one pipelined cordic core between NUM_REQ requesters; a tag pipe
// running alongside the core routes every result back to its issuer.
module cordic_scheduler
  import cordic_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int CORE_LAT = DEF_CORE_LAT,
  parameter int MAX_OUT  = 4,
  parameter int DW       = DEF_DW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    req_mode,
  input  logic [NUM_REQ*DW-1:0] req_x,
  input  logic [NUM_REQ*DW-1:0] req_y,
  input  logic [NUM_REQ*DW-1:0] req_z,
  output logic                  core_mode,
  output logic [DW-1:0]         core_x,
  output logic [DW-1:0]         core_y,
  output logic [DW-1:0]         core_z,
  input  logic [DW-1:0]         core_res1,
  input  logic [DW-1:0]         core_res2,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]         rsp_res1,
  output logic [DW-1:0]         rsp_res2,
  output logic                  busy
);

  localparam int IDW   = $clog2(NUM_REQ);
  localparam int TAG_W = tag_width(NUM_REQ);   // {valid, id}
  // Stage 0 is loaded on the transfer edge together with core_x; the core
  // samples core_x one edge later, so the tag needs one extra stage beyond
  // CORE_LAT+1 to line up with the result it names.
  localparam int DEPTH = CORE_LAT + 2;
  localparam int CW    = $clog2(MAX_OUT + 1);

  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]      out_cnt_q [NUM_REQ];
  logic [CW-1:0]      out_cnt_d [NUM_REQ];
  logic               busy_q, busy_d;
  logic [TAG_W-1:0]   tag_q [DEPTH];

  logic               core_mode_q, core_mode_d;
  logic [DW-1:0]      core_x_q, core_x_d;
  logic [DW-1:0]      core_y_q, core_y_d;
  logic [DW-1:0]      core_z_q, core_z_d;

  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [DW-1:0]      rsp_res1_q, rsp_res2_q;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     grant_idx;
  logic               xfer;
  logic               ret_vld;
  logic [IDW-1:0]     ret_id;
  logic [NUM_REQ-1:0] ret_onehot;

  // A requester may compete only while it has room for another in-flight op.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] && (out_cnt_q[i] < CW'(MAX_OUT));
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .eligible_i  (eligible),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .grant_vld_o (xfer)
  );

  assign req_ready = grant;
  assign ret_vld   = tag_q[DEPTH-1][TAG_W-1];
  assign ret_id    = tag_q[DEPTH-1][IDW-1:0];

  // Next pointer, per-requester counters and busy flag.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    ret_onehot = '0;
    out_cnt_d  = out_cnt_q;
    busy_d     = 1'b0;
    if (xfer) begin
      rr_ptr_d = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
    if (ret_vld) begin
      ret_onehot[ret_id] = 1'b1;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      case ({grant[i], ret_onehot[i]})
        2'b10:   out_cnt_d[i] = out_cnt_q[i] + 1'b1;
        2'b01:   out_cnt_d[i] = out_cnt_q[i] - 1'b1;
        default: out_cnt_d[i] = out_cnt_q[i];
      endcase
      busy_d = busy_d | (out_cnt_d[i] != '0);
    end
  end

  // Operand mux: load the granted requester's slices, otherwise hold.
  always_comb begin
    core_mode_d = core_mode_q;
    core_x_d    = core_x_q;
    core_y_d    = core_y_q;
    core_z_d    = core_z_q;
    if (xfer) begin
      core_mode_d = req_mode[grant_idx];
      core_x_d    = req_x[int'(grant_idx)*DW +: DW];
      core_y_d    = req_y[int'(grant_idx)*DW +: DW];
      core_z_d    = req_z[int'(grant_idx)*DW +: DW];
    end
  end

  // Control state: round-robin pointer, outstanding counters, busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
      busy_q   <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) out_cnt_q[i] <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      busy_q    <= busy_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  // Registered operands presented to the core.
  always_ff @(posedge clk) begin
    if (reset) begin
      core_mode_q <= MODE_ROT;
      core_x_q    <= '0;
      core_y_q    <= '0;
      core_z_q    <= '0;
    end else begin
      core_mode_q <= core_mode_d;
      core_x_q    <= core_x_d;
      core_y_q    <= core_y_d;
      core_z_q    <= core_z_d;
    end
  end

  // Tag pipe: never stalls, one {valid, id} entry per edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < DEPTH; s++) tag_q[s] <= '0;
    end else begin
      tag_q[0] <= {xfer, grant_idx};
      for (int s = 1; s < DEPTH; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  // Return path: capture the core result named by the last tag stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= '0;
      rsp_res1_q  <= '0;
      rsp_res2_q  <= '0;
    end else begin
      rsp_valid_q <= ret_onehot;
      if (ret_vld) begin
        rsp_res1_q <= core_res1;
        rsp_res2_q <= core_res2;
      end
    end
  end

  assign core_mode = core_mode_q;
  assign core_x    = core_x_q;
  assign core_y    = core_y_q;
  assign core_z    = core_z_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_res1  = rsp_res1_q;
  assign rsp_res2  = rsp_res2_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_cordic_scheduler.sv
// Testbench for cordic_scheduler with a delay-line stand-in for the core and
// a queue-based reference model of arbitration, limits and returns.
module tb_cordic_scheduler;

  localparam int N   = 4;
  localparam int LAT = 16;
  localparam int MO  = 4;
  localparam int DW  = 16;
  localparam int RTT = LAT + 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_ready, req_mode;
  logic [N*DW-1:0] req_x, req_y, req_z;
  logic            core_mode;
  logic [DW-1:0]   core_x, core_y, core_z, core_res1, core_res2;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_res1, rsp_res2;
  logic            busy;

  int checks   = 0;
  int failures = 0;

  cordic_scheduler #(.NUM_REQ(N), .CORE_LAT(LAT), .MAX_OUT(MO), .DW(DW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .core_mode(core_mode), .core_x(core_x), .core_y(core_y), .core_z(core_z),
    .core_res1(core_res1), .core_res2(core_res2), .rsp_valid(rsp_valid),
    .rsp_res1(rsp_res1), .rsp_res2(rsp_res2), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in core arithmetic (any deterministic function of the operands will do).
  function automatic logic [DW-1:0] f1(input logic m, input logic [DW-1:0] x, input logic [DW-1:0] y);
    return x ^ {y[7:0], y[15:8]} ^ {DW{m}};
  endfunction
  function automatic logic [DW-1:0] f2(input logic [DW-1:0] x, input logic [DW-1:0] z);
    return z + x;
  endfunction

  // Core stand-in: inputs sampled at edge k appear after edge k+LAT.
  logic [DW-1:0] cp1 [LAT+1];
  logic [DW-1:0] cp2 [LAT+1];
  always @(posedge clk) begin
    cp1[0] <= f1(core_mode, core_x, core_y);
    cp2[0] <= f2(core_x, core_z);
    for (int i = 1; i <= LAT; i++) begin
      cp1[i] <= cp1[i-1];
      cp2[i] <= cp2[i-1];
    end
  end
  assign core_res1 = cp1[LAT];
  assign core_res2 = cp2[LAT];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state: the view after the most recent edge.
  typedef struct {int id; int due; logic [DW-1:0] r1; logic [DW-1:0] r2;} op_t;
  op_t           q[$];
  int            m_cnt [N];
  int            m_rr   = 0;
  int            m_edge = 0;
  logic          m_busy = 1'b0;
  logic [N-1:0]  m_rsp  = '0;
  logic [DW-1:0] m_r1 = '0, m_r2 = '0, m_cx = '0, m_cy = '0, m_cz = '0;
  logic          m_cm = 1'b0;

  function automatic int model_grant();
    for (int i = 0; i < N; i++) begin
      int c;
      c = (m_rr + i) % N;
      if (req_valid[c] && m_cnt[c] < MO) return c;
    end
    return -1;
  endfunction

  // Compare on the falling edge, then advance the model to the next rising edge.
  always @(negedge clk) begin : cmp
    int g;
    logic [N-1:0] exp_rdy;
    op_t o;
    g       = model_grant();
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    chk("req_ready", req_ready, exp_rdy);
    chk("rsp_valid", rsp_valid, m_rsp);
    chk("rsp_res1", rsp_res1, m_r1);
    chk("rsp_res2", rsp_res2, m_r2);
    chk("busy", busy, m_busy);
    chk("core_mode", core_mode, m_cm);
    chk("core_x", core_x, m_cx);
    chk("core_y", core_y, m_cy);
    chk("core_z", core_z, m_cz);
    if (reset) begin
      q.delete();
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_rr = 0; m_busy = 0; m_rsp = '0; m_r1 = '0; m_r2 = '0;
      m_cm = 0; m_cx = '0; m_cy = '0; m_cz = '0;
    end else begin
      m_rsp = '0;
      if (q.size() > 0 && q[0].due == m_edge) begin
        o = q.pop_front();
        m_rsp = N'(1) << o.id;
        m_r1 = o.r1;
        m_r2 = o.r2;
        m_cnt[o.id]--;
      end
      if (g >= 0) begin
        m_cm = req_mode[g];
        m_cx = req_x[g*DW +: DW];
        m_cy = req_y[g*DW +: DW];
        m_cz = req_z[g*DW +: DW];
        q.push_back('{g, m_edge + RTT, f1(m_cm, m_cx, m_cy), f2(m_cx, m_cz)});
        m_cnt[g]++;
        m_rr = (g + 1) % N;
      end
      m_busy = 0;
      for (int i = 0; i < N; i++) if (m_cnt[i] != 0) m_busy = 1;
    end
    m_edge++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    reset = 1'b1; req_valid = '0; req_mode = '0;
    req_x = '0; req_y = '0; req_z = '0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 4'b0000);
    chk("rst_core_x", core_x, 16'h0000);

    // Single operation from requester 0.
    req_valid = 4'b0001; req_mode = 4'b0000;
    req_x[15:0] = 16'h1A60; req_y[15:0] = 16'h0E00; req_z[15:0] = 16'h0200;
    #1 chk("t1_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    chk("t1_core_x", core_x, 16'h1A60);
    n = 0;
    while (rsp_valid == '0 && n < 40) begin tick(); n++; end
    chk("t1_latency", n, RTT);
    chk("t1_rsp_valid", rsp_valid, 4'b0001);
    chk("t1_res1", rsp_res1, 16'h1A6E);
    chk("t1_res2", rsp_res2, 16'h1C60);

    // All four requesters continuously valid.
    do_reset();
    req_valid = 4'b1111; req_mode = 4'b0000;
    req_z = {16'h809F, 16'h01DF, 16'h8310, 16'h0200};
    for (int k = 0; k < 24; k++) begin
      req_x = {$urandom, $urandom}; req_y = {$urandom, $urandom};
      #1;
      if (k < 8) chk("t2_grant", req_ready, 4'b0001 << (k % 4));
      tick();
      if (k >= RTT && k < RTT + 4) chk("t2_rsp_order", rsp_valid, 4'b0001 << ((k - RTT) % 4));
    end
    req_valid = '0;
    repeat (45) tick();

    // Requester 1 alone hits its outstanding limit.
    req_valid = 4'b0010;
    for (int k = 0; k < 24; k++) begin
      req_x = {$urandom, $urandom}; req_mode = 4'($urandom);
      #1 chk("t3_ready1", req_ready[1], (k < 4) || (k >= 19 && k <= 22));
      tick();
      chk("t3_busy", busy, 1'b1);
    end
    req_valid = '0;
    repeat (45) tick();

    // Reset while three operations are in flight.
    do_reset();
    req_valid = 4'b0001;
    repeat (3) tick();
    req_valid = '0;
    repeat (5) tick();
    do_reset();
    chk("t4_busy", busy, 1'b0);
    req_valid = 4'b1111;
    #1 chk("t4_rr_ptr0", req_ready, 4'b0001);
    req_valid = '0;
    for (int k = 0; k < 30; k++) begin
      tick();
      chk("t4_no_rsp", rsp_valid, 4'b0000);
    end

    // Requester 2 (vectoring) and requester 3 contend with rr_ptr at 2.
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b1100; req_mode = 4'b0100;
    req_x[47:32] = 16'h1290; req_y[47:32] = 16'h9000; req_z[47:32] = 16'h80FF;
    req_x[63:48] = 16'h0123; req_y[63:48] = 16'h4567; req_z[63:48] = 16'h89AB;
    #1 chk("t5_grant2", req_ready, 4'b0100);
    tick();
    chk("t5_core_mode2", core_mode, 1'b1);
    chk("t5_core_x2", core_x, 16'h1290);
    req_valid = 4'b1000;
    #1 chk("t5_grant3", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    chk("t5_core_mode3", core_mode, 1'b0);
    n = 1;
    while (rsp_valid != 4'b0100 && n < 40) begin tick(); n++; end
    chk("t5_latency2", n, RTT);
    chk("t5_res1", rsp_res1, 16'hEDFF);
    chk("t5_res2", rsp_res2, 16'h938F);
    tick();
    chk("t5_rsp3", rsp_valid, 4'b1000);
    repeat (5) tick();

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 600; k++) begin
      req_valid = 4'($urandom);
      req_mode  = 4'($urandom);
      req_x = {$urandom, $urandom};
      req_y = {$urandom, $urandom};
      req_z = {$urandom, $urandom};
      reset = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0; req_valid = '0;
    repeat (40) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
